redled_dim_blink_driver: RTL

- Output stage between the 18-bit red-LED PIO register and the DE2 LEDR pins.
- Takes the PIO LED word and a per-bit blink mask (second PIO) and drives the physical LEDs.
- Applies global PWM dimming and a common blink phase, so software sets static patterns only, with no timer interrupts for flashing or dimming.

---
 rtl/redled_dim_blink_driver.sv | 101 ++++++++++
 1 files changed

// File: rtl/redled_dim_blink_driver.sv
// -----------------------------------------------------------------------------
// redled_dim_blink_driver
// Output stage between the red-LED PIO word and the LEDR pins. Adds global PWM
// dimming and a shared blink phase so software only writes static patterns.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   led_in       LED word from PIO (1 = LED requested on)
//   blink_en     per-bit blink mask (1 = bit follows blink phase)
//   duty         brightness, 0 = off, all-ones = full on
//   enable       global LED enable
//   phase_sync   one-cycle pulse: restart blink timing with phase on
//   led_out      registered LED drive
//   blink_phase  current blink phase (1 = blinking bits lit)
// -----------------------------------------------------------------------------
module redled_dim_blink_driver #(
  parameter int unsigned WIDTH        = 18,
  parameter int unsigned PRESCALE_DIV = 50000,
  parameter int unsigned BLINK_TICKS  = 250,
  parameter int unsigned PWM_BITS     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [WIDTH-1:0]    blink_en,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                enable,
  input  logic                phase_sync,
  output logic [WIDTH-1:0]    led_out,
  output logic                blink_phase
);

  localparam int unsigned PS_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int unsigned BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [WIDTH-1:0]    led_q,      led_d;
  logic [WIDTH-1:0]    led_out_q,  led_out_d;
  logic [PS_W-1:0]     prescale_q, prescale_d;
  logic [BL_W-1:0]     blink_q,    blink_d;
  logic [PWM_BITS-1:0] pwm_q,      pwm_d;
  logic                phase_q,    phase_d;

  logic tick_c;
  logic pwm_on_c;

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      led_out_q  <= '0;
      prescale_q <= '0;
      blink_q    <= '0;
      pwm_q      <= '0;
      phase_q    <= 1'b1;
    end else begin
      led_q      <= led_d;
      led_out_q  <= led_out_d;
      prescale_q <= prescale_d;
      blink_q    <= blink_d;
      pwm_q      <= pwm_d;
      phase_q    <= phase_d;
    end
  end

  // Next-state logic: prescaler, blink timing, PWM and output gating
  always_comb begin
    led_d      = led_in;
    prescale_d = prescale_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    pwm_d      = pwm_q + PWM_BITS'(1);

    tick_c   = (prescale_q == PS_W'(PRESCALE_DIV - 1));
    // All-ones duty must be fully on, which a plain less-than cannot reach
    pwm_on_c = (&duty) | (pwm_q < duty);

    if (phase_sync) begin
      // Sync wins over a coincident tick; that tick is dropped
      prescale_d = '0;
      blink_d    = '0;
      phase_d    = 1'b1;
    end else begin
      prescale_d = tick_c ? '0 : prescale_q + PS_W'(1);
      if (tick_c) begin
        if (blink_q == BL_W'(BLINK_TICKS - 1)) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + BL_W'(1);
        end
      end
    end

    led_out_d = {WIDTH{enable & pwm_on_c}} & led_q & (~blink_en | {WIDTH{phase_q}});
  end

  assign led_out     = led_out_q;
  assign blink_phase = phase_q;

endmodule
